// File: rtl/integer_divide_pkg.sv
// rtl/integer_divide_pkg.sv - shared sizing helpers and stage-record layout for integer_divide_pipe
package integer_divide_pkg;

    // Partial remainder is one bit wider than the divisor while it is compared.
    localparam int PREM_EXTRA_BITS = 1;
    localparam int SIGN_BITS       = 2;
    localparam int FLAG_BITS       = 2;
    localparam int CTL_BITS        = SIGN_BITS + FLAG_BITS;

    localparam int CTL_Q_SIGN = 3;
    localparam int CTL_R_SIGN = 2;
    localparam int CTL_DBZ    = 1;
    localparam int CTL_OVF    = 0;

    function automatic int calc_nstages(input int dividend_width, input int bits_per_stage);
        return (dividend_width + bits_per_stage - 1) / bits_per_stage;
    endfunction

    function automatic int stage_bits(input int dividend_width, input int bits_per_stage,
                                      input int stage_index);
        int left;
        left = dividend_width - stage_index * bits_per_stage;
        return (left < bits_per_stage) ? left : bits_per_stage;
    endfunction

endpackage

// File: rtl/integer_divide_stage.sv
// rtl/integer_divide_stage.sv - one registered restoring-division stage, MSB-first
module integer_divide_stage
    import integer_divide_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIVISOR_WIDTH  = 32,
    parameter int BITS_PER_STAGE = 1,
    parameter int TAG_WIDTH      = 1,
    parameter int STAGE_INDEX    = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce,
    input  logic                      in_valid,
    input  logic [TAG_WIDTH-1:0]      in_tag,
    input  logic [CTL_BITS-1:0]       in_ctl,
    input  logic [DIVIDEND_WIDTH-1:0] in_work,
    input  logic [DIVISOR_WIDTH-1:0]  in_rem,
    input  logic [DIVISOR_WIDTH-1:0]  in_divisor,
    output logic                      out_valid,
    output logic [TAG_WIDTH-1:0]      out_tag,
    output logic [CTL_BITS-1:0]       out_ctl,
    output logic [DIVIDEND_WIDTH-1:0] out_work,
    output logic [DIVISOR_WIDTH-1:0]  out_rem,
    output logic [DIVISOR_WIDTH-1:0]  out_divisor
);

    localparam int NBITS      = stage_bits(DIVIDEND_WIDTH, BITS_PER_STAGE, STAGE_INDEX);
    localparam int PREM_WIDTH = DIVISOR_WIDTH + PREM_EXTRA_BITS;

    logic [DIVIDEND_WIDTH-1:0] work_next;
    logic [DIVISOR_WIDTH-1:0]  rem_next;
    logic [PREM_WIDTH-1:0]     prem;
    logic                      take;

    // work shifts dividend bits out of the top and quotient bits in at the bottom
    always_comb begin
        work_next = in_work;
        rem_next  = in_rem;
        prem      = '0;
        take      = 1'b0;
        for (int i = 0; i < BITS_PER_STAGE; i++) begin
            if (i < NBITS) begin
                prem      = {rem_next, work_next[DIVIDEND_WIDTH-1]};
                take      = (prem >= PREM_WIDTH'(in_divisor));
                rem_next  = take ? DIVISOR_WIDTH'(prem - PREM_WIDTH'(in_divisor))
                                 : prem[DIVISOR_WIDTH-1:0];
                work_next = {work_next[DIVIDEND_WIDTH-2:0], take};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (ce) begin
            out_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            out_tag     <= in_tag;
            out_ctl     <= in_ctl;
            out_work    <= work_next;
            out_rem     <= rem_next;
            out_divisor <= in_divisor;
        end
    end

endmodule

// File: rtl/integer_divide_pipe.sv
// rtl/integer_divide_pipe.sv - fully pipelined signed/unsigned integer divider with tag and flags
module integer_divide_pipe
    import integer_divide_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIVISOR_WIDTH  = 32,
    parameter int BITS_PER_STAGE = 1,
    parameter int TAG_WIDTH      = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce,
    input  logic                      in_valid,
    input  logic                      is_signed,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    input  logic [TAG_WIDTH-1:0]      in_tag,
    output logic                      out_valid,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic [TAG_WIDTH-1:0]      out_tag,
    output logic                      div_by_zero,
    output logic                      overflow
);

    localparam int NSTAGES = calc_nstages(DIVIDEND_WIDTH, BITS_PER_STAGE);
    localparam logic [DIVIDEND_WIDTH-1:0] DIVIDEND_MIN = {1'b1, {(DIVIDEND_WIDTH-1){1'b0}}};

    logic                      dividend_neg;
    logic                      divisor_neg;
    logic                      zero_divisor;
    logic [DIVIDEND_WIDTH-1:0] dividend_mag;
    logic [DIVISOR_WIDTH-1:0]  divisor_mag;
    logic [CTL_BITS-1:0]       ctl_in;

    // On divide-by-zero the raw dividend bits pass through unsigned so they reappear in the remainder.
    always_comb begin
        dividend_neg         = is_signed & dividend[DIVIDEND_WIDTH-1];
        divisor_neg          = is_signed & divisor[DIVISOR_WIDTH-1];
        zero_divisor         = (divisor == '0);
        dividend_mag         = (dividend_neg & ~zero_divisor) ? -dividend : dividend;
        divisor_mag          = divisor_neg ? -divisor : divisor;
        ctl_in               = '0;
        ctl_in[CTL_Q_SIGN]   = ~zero_divisor & (dividend_neg ^ divisor_neg);
        ctl_in[CTL_R_SIGN]   = ~zero_divisor & dividend_neg;
        ctl_in[CTL_DBZ]      = zero_divisor;
        ctl_in[CTL_OVF]      = is_signed & (dividend == DIVIDEND_MIN) & (divisor == '1);
    end

    logic                      s0_valid;
    logic [TAG_WIDTH-1:0]      s0_tag;
    logic [CTL_BITS-1:0]       s0_ctl;
    logic [DIVIDEND_WIDTH-1:0] s0_work;
    logic [DIVISOR_WIDTH-1:0]  s0_divisor;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid <= 1'b0;
        end else if (ce) begin
            s0_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            s0_tag     <= in_tag;
            s0_ctl     <= ctl_in;
            s0_work    <= dividend_mag;
            s0_divisor <= divisor_mag;
        end
    end

    logic                      valid_s   [0:NSTAGES];
    logic [TAG_WIDTH-1:0]      tag_s     [0:NSTAGES];
    logic [CTL_BITS-1:0]       ctl_s     [0:NSTAGES];
    logic [DIVIDEND_WIDTH-1:0] work_s    [0:NSTAGES];
    logic [DIVISOR_WIDTH-1:0]  rem_s     [0:NSTAGES];
    logic [DIVISOR_WIDTH-1:0]  divisor_s [0:NSTAGES];

    assign valid_s[0]   = s0_valid;
    assign tag_s[0]     = s0_tag;
    assign ctl_s[0]     = s0_ctl;
    assign work_s[0]    = s0_work;
    assign rem_s[0]     = '0;
    assign divisor_s[0] = s0_divisor;

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        integer_divide_stage #(
            .DIVIDEND_WIDTH (DIVIDEND_WIDTH),
            .DIVISOR_WIDTH  (DIVISOR_WIDTH),
            .BITS_PER_STAGE (BITS_PER_STAGE),
            .TAG_WIDTH      (TAG_WIDTH),
            .STAGE_INDEX    (k)
        ) u_stage (
            .clk         (clk),
            .rst         (rst),
            .ce          (ce),
            .in_valid    (valid_s[k]),
            .in_tag      (tag_s[k]),
            .in_ctl      (ctl_s[k]),
            .in_work     (work_s[k]),
            .in_rem      (rem_s[k]),
            .in_divisor  (divisor_s[k]),
            .out_valid   (valid_s[k+1]),
            .out_tag     (tag_s[k+1]),
            .out_ctl     (ctl_s[k+1]),
            .out_work    (work_s[k+1]),
            .out_rem     (rem_s[k+1]),
            .out_divisor (divisor_s[k+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            out_tag     <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (ce) begin
            out_valid   <= valid_s[NSTAGES];
            div_by_zero <= valid_s[NSTAGES] & ctl_s[NSTAGES][CTL_DBZ];
            overflow    <= valid_s[NSTAGES] & ctl_s[NSTAGES][CTL_OVF];
            if (valid_s[NSTAGES]) begin
                quotient  <= ctl_s[NSTAGES][CTL_Q_SIGN] ? -work_s[NSTAGES] : work_s[NSTAGES];
                remainder <= ctl_s[NSTAGES][CTL_R_SIGN] ? -rem_s[NSTAGES] : rem_s[NSTAGES];
                out_tag   <= tag_s[NSTAGES];
            end
        end
    end

endmodule

// File: tb/tb_integer_divide_pipe.sv
// tb/tb_integer_divide_pipe.sv - directed and model-checked bench for integer_divide_pipe
module tb_integer_divide_pipe;

    localparam int DW = 32;
    localparam int VW = 32;
    localparam int TW = 8;

    typedef struct packed {
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic [TW-1:0] tag;
        logic          dbz;
        logic          ovf;
    } res_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic          in_valid;
    logic          is_signed;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic [TW-1:0] out_tag;
    logic          div_by_zero;
    logic          overflow;

    logic          ce3;
    logic          in_valid3;
    logic          is_signed3;
    logic [15:0]   dividend3;
    logic [7:0]    divisor3;
    logic [0:0]    in_tag3;
    logic          out_valid3;
    logic [15:0]   quotient3;
    logic [7:0]    remainder3;
    logic [0:0]    out_tag3;
    logic          div_by_zero3;
    logic          overflow3;

    int   compared   = 0;
    int   mismatched = 0;
    int   en_edges   = 0;
    bit   rand_ce    = 1'b0;
    res_t exp_q[$];
    res_t res_q[$];
    int   acc_q[$];
    int   stamp_q[$];

    always #5 clk = ~clk;

    integer_divide_pipe #(
        .DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW), .BITS_PER_STAGE(1), .TAG_WIDTH(TW)
    ) u_dut (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .in_tag(in_tag), .out_valid(out_valid),
        .quotient(quotient), .remainder(remainder), .out_tag(out_tag),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    integer_divide_pipe #(
        .DIVIDEND_WIDTH(16), .DIVISOR_WIDTH(8), .BITS_PER_STAGE(3), .TAG_WIDTH(1)
    ) u_dut3 (
        .clk(clk), .rst(rst), .ce(ce3), .in_valid(in_valid3), .is_signed(is_signed3),
        .dividend(dividend3), .divisor(divisor3), .in_tag(in_tag3), .out_valid(out_valid3),
        .quotient(quotient3), .remainder(remainder3), .out_tag(out_tag3),
        .div_by_zero(div_by_zero3), .overflow(overflow3)
    );

    // Stamps accepted operations and emitted results with the enabled-edge count.
    always @(posedge clk) begin
        bit en;
        bit acc;
        en  = ce && !rst;
        acc = en && in_valid;
        #1;
        if (en) begin
            en_edges++;
            if (acc) acc_q.push_back(en_edges);
            if (out_valid) begin
                res_q.push_back({quotient, remainder, out_tag, div_by_zero, overflow});
                stamp_q.push_back(en_edges);
            end
        end
    end

    function automatic res_t mk(input logic [DW-1:0] q, input logic [VW-1:0] r,
                                input logic [TW-1:0] t, input logic d, input logic o);
        res_t x;
        x.q = q; x.r = r; x.tag = t; x.dbz = d; x.ovf = o;
        return x;
    endfunction

    task automatic clear_queues;
        exp_q.delete(); res_q.delete(); acc_q.delete(); stamp_q.delete();
    endtask

    task automatic send(input bit s, input logic [DW-1:0] a, input logic [VW-1:0] b,
                        input logic [TW-1:0] t, input res_t e);
        @(negedge clk);
        is_signed = s; dividend = a; divisor = b; in_tag = t; in_valid = 1'b1;
        ce = rand_ce ? 1'($urandom_range(0, 1)) : 1'b1;
        while (!ce) begin
            @(negedge clk);
            ce = rand_ce ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        exp_q.push_back(e);
    endtask

    task automatic drain(input int n, output bit ok);
        int cyc = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (res_q.size() < n && cyc < 3000) begin
            ce = rand_ce ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            cyc++;
        end
        ce = 1'b1;
        repeat (40) @(negedge clk);
        ok = (res_q.size() == n);
    endtask

    function automatic res_t model(input bit s, input logic [DW-1:0] a, input logic [VW-1:0] b,
                                   input logic [TW-1:0] t);
        logic signed [DW-1:0] sa;
        logic signed [VW-1:0] sb;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        sa = a; sb = b;
        if (s) begin q = sa / sb; r = sa % sb; end
        else   begin q = a / b;   r = a % b;   end
        return mk(q, r, t, 1'b0, 1'b0);
    endfunction

    task automatic test_reset;
        @(negedge clk);
        compared++;
        if ({out_valid, div_by_zero, overflow} !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_flags: got %b, expected 000", {out_valid, div_by_zero, overflow});
        end
        compared++;
        if ({quotient, remainder, out_tag} !== '0) begin
            mismatched++;
            $display("FAIL reset_data: got q=%h r=%h tag=%h, expected zeros", quotient, remainder, out_tag);
        end
        clear_queues();
        rst = 1'b0; ce = 1'b1; ce3 = 1'b1;
        repeat (50) @(negedge clk);
        compared++;
        if (res_q.size() != 0) begin
            mismatched++;
            $display("FAIL reset_idle: got %0d results, expected 0", res_q.size());
        end
    endtask

    task automatic test_unsigned_latency;
        bit ok;
        clear_queues();
        send(1'b0, 32'd100, 32'd7, 8'h11, mk(32'd14, 32'd2, 8'h11, 1'b0, 1'b0));
        drain(1, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL unsigned_count: got %0d results, expected 1", res_q.size());
        end
        if (res_q.size() > 0 && acc_q.size() > 0) begin
            compared++;
            if (res_q[0] !== exp_q[0]) begin
                mismatched++;
                $display("FAIL unsigned_100_7: got %h, expected %h", res_q[0], exp_q[0]);
            end
            compared++;
            if (stamp_q[0] - acc_q[0] + 1 != 34) begin
                mismatched++;
                $display("FAIL unsigned_latency: got %0d, expected 34", stamp_q[0] - acc_q[0] + 1);
            end
        end
    endtask

    task automatic test_signed;
        bit ok;
        clear_queues();
        send(1'b1, 32'hFFFF_FFF9, 32'd2,         8'h21, mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 8'h21, 1'b0, 1'b0));
        send(1'b1, 32'd7,         32'hFFFF_FFFE, 8'h22, mk(32'hFFFF_FFFD, 32'd1,         8'h22, 1'b0, 1'b0));
        send(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 8'h23, mk(32'd3,         32'hFFFF_FFFF, 8'h23, 1'b0, 1'b0));
        drain(3, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL signed_count: got %0d results, expected 3", res_q.size());
        end
        for (int i = 0; i < 3 && i < res_q.size(); i++) begin
            compared++;
            if (res_q[i] !== exp_q[i]) begin
                mismatched++;
                $display("FAIL signed[%0d]: got %h, expected %h", i, res_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_corners;
        bit ok;
        clear_queues();
        send(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 8'h31, mk(32'h8000_0000, 32'd0, 8'h31, 1'b0, 1'b1));
        send(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 8'h32, mk(32'd0, 32'h8000_0000, 8'h32, 1'b0, 1'b0));
        send(1'b0, 32'd55,        32'd0,         8'h33, mk(32'hFFFF_FFFF, 32'd55, 8'h33, 1'b1, 1'b0));
        send(1'b1, 32'hFFFF_FFF9, 32'd0,         8'h34, mk(32'hFFFF_FFFF, 32'hFFFF_FFF9, 8'h34, 1'b1, 1'b0));
        drain(4, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL corner_count: got %0d results, expected 4", res_q.size());
        end
        for (int i = 0; i < 4 && i < res_q.size(); i++) begin
            compared++;
            if (res_q[i] !== exp_q[i]) begin
                mismatched++;
                $display("FAIL corner[%0d]: got %h, expected %h", i, res_q[i], exp_q[i]);
            end
        end
        compared++;
        if ({out_valid, div_by_zero, overflow, remainder} !== {3'b000, 32'hFFFF_FFF9}) begin
            mismatched++;
            $display("FAIL idle_hold: got v=%b dbz=%b ovf=%b r=%h, expected 0 0 0 fffffff9",
                     out_valid, div_by_zero, overflow, remainder);
        end
    endtask

    task automatic run_random(input string name, input int n);
        bit ok;
        int lat_bad = 0;
        clear_queues();
        for (int i = 0; i < n; i++) begin
            logic [DW-1:0] a;
            logic [VW-1:0] b;
            bit s;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            s = 1'($urandom_range(0, 1));
            if (b == 0) b = 32'd1;
            if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            send(s, a, b, 8'(i), model(s, a, b, 8'(i)));
        end
        drain(n, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL %s_count: got %0d results, expected %0d", name, res_q.size(), n);
        end
        for (int i = 0; i < n && i < res_q.size(); i++) begin
            compared++;
            if (res_q[i] !== exp_q[i]) begin
                mismatched++;
                $display("FAIL %s[%0d]: got %h, expected %h", name, i, res_q[i], exp_q[i]);
            end
            if (i < acc_q.size() && stamp_q[i] - acc_q[i] + 1 != 34) lat_bad++;
        end
        compared++;
        if (lat_bad != 0) begin
            mismatched++;
            $display("FAIL %s_latency: got %0d results off 34 enabled cycles, expected 0", name, lat_bad);
        end
    endtask

    task automatic test_back_to_back;
        rand_ce = 1'b0;
        run_random("back_to_back", 1000);
    endtask

    task automatic test_ce_stall;
        rand_ce = 1'b1;
        run_random("ce_stall", 60);
        rand_ce = 1'b0;
    endtask

    task automatic test_reset_inflight;
        bit ok;
        clear_queues();
        for (int i = 0; i < 10; i++) send(1'b0, 32'd1000 + i, 32'd3, 8'(i), mk('0, '0, '0, 1'b0, 1'b0));
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        compared++;
        if ({out_valid, quotient, remainder, out_tag, div_by_zero, overflow} !== '0) begin
            mismatched++;
            $display("FAIL inflight_reset_outputs: got v=%b q=%h r=%h tag=%h, expected zeros",
                     out_valid, quotient, remainder, out_tag);
        end
        repeat (50) @(negedge clk);
        compared++;
        if (res_q.size() != 0) begin
            mismatched++;
            $display("FAIL inflight_discard: got %0d results, expected 0", res_q.size());
        end
        clear_queues();
        send(1'b0, 32'd9, 32'd4, 8'h5A, mk(32'd2, 32'd1, 8'h5A, 1'b0, 1'b0));
        drain(1, ok);
        compared++;
        if (!ok || res_q[0] !== exp_q[0]) begin
            mismatched++;
            $display("FAIL after_reset_op: got %0d results first=%h, expected 1 of %h",
                     res_q.size(), (res_q.size() > 0) ? res_q[0] : '0, exp_q[0]);
        end
    endtask

    task automatic test_bps3;
        logic [15:0] a3 [3] = '{16'hFFFF, 16'd1000, 16'hFF9C};
        logic [7:0]  b3 [3] = '{8'h03, 8'd7, 8'd7};
        bit          s3 [3] = '{1'b0, 1'b0, 1'b1};
        logic [15:0] q3 [3] = '{16'h5555, 16'd142, 16'hFFF2};
        logic [7:0]  r3 [3] = '{8'h00, 8'd6, 8'hFE};
        for (int i = 0; i < 3; i++) begin
            int cyc;
            @(negedge clk);
            ce3 = 1'b1; in_valid3 = 1'b1; is_signed3 = s3[i];
            dividend3 = a3[i]; divisor3 = b3[i]; in_tag3 = 1'(i);
            @(posedge clk);
            cyc = 1;
            @(negedge clk);
            in_valid3 = 1'b0;
            while (!out_valid3 && cyc < 100) begin
                @(posedge clk);
                cyc++;
                @(negedge clk);
            end
            compared++;
            if (cyc != 8) begin
                mismatched++;
                $display("FAIL bps3_latency[%0d]: got %0d, expected 8", i, cyc);
            end
            compared++;
            if ({quotient3, remainder3, out_tag3} !== {q3[i], r3[i], 1'(i)}) begin
                mismatched++;
                $display("FAIL bps3_result[%0d]: got q=%h r=%h tag=%h, expected q=%h r=%h tag=%h",
                         i, quotient3, remainder3, out_tag3, q3[i], r3[i], 1'(i));
            end
        end
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; in_valid = 1'b1; is_signed = 1'b0;
        dividend = 32'd77; divisor = 32'd5; in_tag = 8'hAA;
        ce3 = 1'b0; in_valid3 = 1'b0; is_signed3 = 1'b0;
        dividend3 = '0; divisor3 = '0; in_tag3 = '0;
        repeat (2) @(posedge clk);
        in_valid = 1'b0;
        test_reset();
        test_unsigned_latency();
        test_signed();
        test_corners();
        test_back_to_back();
        test_ce_stall();
        test_reset_inflight();
        test_bps3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
